// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding, time limits and wrap-add helper for alarm_ctrl
package alarm_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HOUR = 6'd23;

  // Moduli used when adding a minute offset to an hour:minute pair
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;

  // Add delta minutes (1..59) to hour:minute; returns {hour, minute}
  function automatic logic [11:0] wrap_add_min(input logic [5:0] hour,
                                               input logic [5:0] minute,
                                               input int unsigned delta);
    logic [6:0] m;
    logic [6:0] h;
    m = {1'b0, minute} + 7'(delta);
    h = {1'b0, hour};
    if (m >= 7'(MIN_MOD)) begin
      m = m - 7'(MIN_MOD);
      h = h + 7'd1;
    end
    if (h >= 7'(HOUR_MOD)) begin
      h = h - 7'(HOUR_MOD);
    end
    return {6'(h), 6'(m)};
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - buzzer square wave: TONE_DIV cycle half-period counter plus toggle flop
module tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic buzz
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TONE_DIV - 1);

  logic [CW-1:0] cnt;

  // Count half-periods while enabled; clear holds the wave low and restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      buzz <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      buzz <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        buzz <= ~buzz;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller; optional snooze under ALARM_SNOOZE_EN
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int TONE_DIV   = 50000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [5:0] i_hour,
  input  logic       i_arm_tgl,
  input  logic       i_set_min,
  input  logic       i_set_hour,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic [5:0] o_alm_min,
  output logic [5:0] o_alm_hour,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_buzz
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  // Time buses packed as {hour, min, sec}; each 6-bit field is filtered on its own
  logic [17:0] raw_time;
  logic [17:0] sync1;
  logic [17:0] sync2;
  logic [17:0] sync3;
  logic [17:0] acc_time;
  logic        sec_tick;

  assign raw_time = {i_hour, i_min, i_sec};

  // Two-flop synchronizer plus one extra stage holding the previous synchronized sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw_time;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Accept a field only when two consecutive synchronized samples agree; tick on a new second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_time <= '0;
      sec_tick <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (sync2[b*6 +: 6] == sync3[b*6 +: 6]) begin
          acc_time[b*6 +: 6] <= sync2[b*6 +: 6];
        end
      end
      sec_tick <= (sync2[5:0] == sync3[5:0]) && (sync2[5:0] != acc_time[5:0]);
    end
  end

  logic [5:0] acc_sec;
  logic [5:0] acc_min;
  logic [5:0] acc_hour;
  logic       alm_match;

  assign acc_sec   = acc_time[5:0];
  assign acc_min   = acc_time[11:6];
  assign acc_hour  = acc_time[17:12];
  assign alm_match = (acc_hour == o_alm_hour) && (acc_min == o_alm_min) && (acc_sec == 6'd0);

  // Alarm time setting, wraps independently with no minute-to-hour carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alm_min  <= 6'd0;
      o_alm_hour <= 6'd0;
    end else begin
      if (i_set_min) begin
        o_alm_min <= (o_alm_min >= MAX_MIN) ? 6'd0 : o_alm_min + 6'd1;
      end
      if (i_set_hour) begin
        o_alm_hour <= (o_alm_hour >= MAX_HOUR) ? 6'd0 : o_alm_hour + 6'd1;
      end
    end
  end

  state_t     state;
  logic [7:0] ring_cnt;

`ifdef ALARM_SNOOZE_EN
  logic [5:0]  snz_min;
  logic [5:0]  snz_hour;
  logic [11:0] snz_next;
  logic        snz_match;

  assign snz_next  = wrap_add_min(acc_hour, acc_min, SNOOZE_MIN);
  assign snz_match = (acc_hour == snz_hour) && (acc_min == snz_min) && (acc_sec == 6'd0);
`else
  logic unused_snooze;
  localparam int unused_snooze_min = SNOOZE_MIN;
  assign unused_snooze = i_snooze;
`endif

  // Controller FSM with registered status flags; priority arm_tgl > stop > snooze > time match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ring_cnt  <= 8'd0;
      o_armed   <= 1'b0;
      o_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_min   <= 6'd0;
      snz_hour  <= 6'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_arm_tgl) begin
            state   <= ST_ARMED;
            o_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (i_arm_tgl) begin
            state   <= ST_IDLE;
            o_armed <= 1'b0;
          end else if (sec_tick && alm_match) begin
            state     <= ST_RINGING;
            ring_cnt  <= 8'd0;
            o_ringing <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_arm_tgl) begin
            state     <= ST_IDLE;
            o_armed   <= 1'b0;
            o_ringing <= 1'b0;
          end else if (i_stop) begin
            state     <= ST_ARMED;
            o_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (i_snooze) begin
            state     <= ST_SNOOZE;
            o_ringing <= 1'b0;
            snz_hour  <= snz_next[11:6];
            snz_min   <= snz_next[5:0];
`endif
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state     <= ST_ARMED;
              o_ringing <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (i_arm_tgl) begin
            state   <= ST_IDLE;
            o_armed <= 1'b0;
          end else if (i_stop) begin
            state <= ST_ARMED;
          end else if (sec_tick && snz_match) begin
            state     <= ST_RINGING;
            ring_cnt  <= 8'd0;
            o_ringing <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          o_armed   <= 1'b0;
          o_ringing <= 1'b0;
        end
      endcase
    end
  end

  logic tone_clr;
  assign tone_clr = ~o_ringing;

  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (o_ringing),
    .clr  (tone_clr),
    .buzz (o_buzz)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl: vector table, directed corners, random vs model
module tb_alarm_ctrl;

  localparam int TONE_DIV   = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 5;

  localparam int OP_ARM  = 0;
  localparam int OP_SETM = 1;
  localparam int OP_SETH = 2;
  localparam int OP_STOP = 3;
  localparam int OP_SNZ  = 4;
  localparam int OP_TIME = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] i_sec = '0, i_min = '0, i_hour = '0;
  logic       i_arm_tgl = 1'b0, i_set_min = 1'b0, i_set_hour = 1'b0, i_stop = 1'b0, i_snooze = 1'b0;
  logic [5:0] o_alm_min, o_alm_hour;
  logic       o_armed, o_ringing, o_buzz;

  int checks = 0;
  int failures = 0;

  alarm_ctrl #(
    .TONE_DIV  (TONE_DIV),
    .RING_SEC  (RING_SEC),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sec     (i_sec),
    .i_min     (i_min),
    .i_hour    (i_hour),
    .i_arm_tgl (i_arm_tgl),
    .i_set_min (i_set_min),
    .i_set_hour(i_set_hour),
    .i_stop    (i_stop),
    .i_snooze  (i_snooze),
    .o_alm_min (o_alm_min),
    .o_alm_hour(o_alm_hour),
    .o_armed   (o_armed),
    .o_ringing (o_ringing),
    .o_buzz    (o_buzz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int rep;
    int hh;
    int mm;
    int ss;
    int ex_armed;
    int ex_ring;
    int ex_ah;
    int ex_am;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int op);
    case (op)
      OP_ARM:  i_arm_tgl = 1'b1;
      OP_SETM: i_set_min = 1'b1;
      OP_SETH: i_set_hour = 1'b1;
      OP_STOP: i_stop = 1'b1;
      OP_SNZ:  i_snooze = 1'b1;
      default: ;
    endcase
    step(1);
    i_arm_tgl = 1'b0; i_set_min = 1'b0; i_set_hour = 1'b0; i_stop = 1'b0; i_snooze = 1'b0;
  endtask

  task automatic pulse_n(input int op, input int n);
    repeat (n) pulse(op);
    step(2);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    i_hour = 6'(h); i_min = 6'(m); i_sec = 6'(s);
    step(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_arm_tgl = 1'b0; i_set_min = 1'b0; i_set_hour = 1'b0; i_stop = 1'b0; i_snooze = 1'b0;
    i_hour = '0; i_min = '0; i_sec = '0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  // Behavioural reference: abstract flags, alarm as numbers, time as seconds of day
  int m_on, m_ring, m_snz, m_ticks, m_ah, m_am, m_tgt, m_t;

  task automatic m_reset();
    m_on = 0; m_ring = 0; m_snz = 0; m_ticks = 0; m_ah = 0; m_am = 0; m_tgt = 0; m_t = 0;
  endtask

  task automatic m_op(input int op);
    case (op)
      OP_ARM: begin
        if (m_on == 0) m_on = 1;
        else begin m_on = 0; m_ring = 0; m_snz = 0; end
      end
      OP_SETM: m_am = (m_am + 1) % 60;
      OP_SETH: m_ah = (m_ah + 1) % 24;
      OP_STOP: begin m_ring = 0; m_snz = 0; end
      OP_SNZ: begin
`ifdef ALARM_SNOOZE_EN
        if (m_ring == 1) begin
          m_ring = 0; m_snz = 1;
          m_tgt = (m_t / 60 + SNOOZE_MIN) % 1440;
        end
`endif
      end
      default: ;
    endcase
  endtask

  task automatic m_new_time(input int nt);
    bit tick;
    tick = (nt % 60) != (m_t % 60);
    m_t = nt;
    if (tick) begin
      if (m_ring == 1) begin
        m_ticks++;
        if (m_ticks == RING_SEC) m_ring = 0;
      end else if (m_snz == 1) begin
        if (m_t % 60 == 0 && m_t / 60 == m_tgt) begin m_snz = 0; m_ring = 1; m_ticks = 0; end
      end else if (m_on == 1) begin
        if (m_t == (m_ah * 60 + m_am) * 60) begin m_ring = 1; m_ticks = 0; end
      end
    end
  endtask

  int n, k, r, nt;

  initial begin
    // Vector table: op, repeat, time, expected armed/ringing/alarm hour/alarm minute
    tbl[0] = '{OP_SETH, 7,  0, 0, 0,  0, 0, 7, 0};
    tbl[1] = '{OP_SETM, 30, 0, 0, 0,  0, 0, 7, 30};
    tbl[2] = '{OP_ARM,  1,  0, 0, 0,  1, 0, 7, 30};
    tbl[3] = '{OP_TIME, 1,  7, 29, 59, 1, 0, 7, 30};
    tbl[4] = '{OP_TIME, 1,  7, 30, 0,  1, 1, 7, 30};
    tbl[5] = '{OP_SETM, 1,  0, 0, 0,  1, 1, 7, 31};
    tbl[6] = '{OP_STOP, 1,  0, 0, 0,  1, 0, 7, 31};
    tbl[7] = '{OP_SETM, 29, 0, 0, 0,  1, 0, 7, 0};
    tbl[8] = '{OP_SETH, 17, 0, 0, 0,  1, 0, 0, 0};
    tbl[9] = '{OP_ARM,  1,  0, 0, 0,  0, 0, 0, 0};

    do_reset();
    chk("reset_armed", o_armed, 0);
    chk("reset_ringing", o_ringing, 0);
    chk("reset_buzz", o_buzz, 0);
    chk("reset_alm_hour", o_alm_hour, 0);
    chk("reset_alm_min", o_alm_min, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].op == OP_TIME) set_time(tbl[i].hh, tbl[i].mm, tbl[i].ss);
      else pulse_n(tbl[i].op, tbl[i].rep);
      chk($sformatf("tbl%0d_armed", i), o_armed, tbl[i].ex_armed);
      chk($sformatf("tbl%0d_ringing", i), o_ringing, tbl[i].ex_ring);
      chk($sformatf("tbl%0d_alm_hour", i), o_alm_hour, tbl[i].ex_ah);
      chk($sformatf("tbl%0d_alm_min", i), o_alm_min, tbl[i].ex_am);
    end

    // Ring latency and first buzzer edge
    do_reset();
    pulse_n(OP_SETH, 7);
    pulse_n(OP_SETM, 30);
    pulse_n(OP_ARM, 1);
    set_time(7, 29, 59);
    i_hour = 6'd7; i_min = 6'd30; i_sec = 6'd0;
    n = 0;
    while (!o_ringing && n < 20) begin step(1); n++; end
    chk("ring_rise", o_ringing, 1);
    chk("ring_latency_in_window", int'(n >= 3 && n <= 10), 1);
    chk("buzz_low_at_ring_rise", o_buzz, 0);
    k = 0;
    while (!o_buzz && k < 50) begin step(1); k++; end
    chk("buzz_first_rise_cycles", k, TONE_DIV);

    // Auto-stop after RING_SEC second ticks
    set_time(7, 30, 1);
    set_time(7, 30, 2);
    chk("timeout_still_ringing", o_ringing, 1);
    set_time(7, 30, 3);
    chk("timeout_ringing", o_ringing, 0);
    chk("timeout_armed", o_armed, 1);
    chk("timeout_buzz", o_buzz, 0);

    // stop with snooze -> ARMED; arm_tgl with stop -> IDLE
    set_time(7, 29, 59);
    set_time(7, 30, 0);
    chk("rering", o_ringing, 1);
    i_stop = 1'b1; i_snooze = 1'b1;
    step(1);
    i_stop = 1'b0; i_snooze = 1'b0;
    step(2);
    chk("stop_snz_ringing", o_ringing, 0);
    chk("stop_snz_armed", o_armed, 1);
    set_time(7, 29, 59);
    set_time(7, 30, 0);
    chk("rering2", o_ringing, 1);
    i_stop = 1'b1; i_arm_tgl = 1'b1;
    step(1);
    i_stop = 1'b0; i_arm_tgl = 1'b0;
    step(2);
    chk("arm_stop_ringing", o_ringing, 0);
    chk("arm_stop_armed", o_armed, 0);

    // Snooze across midnight
    do_reset();
    pulse_n(OP_SETH, 23);
    pulse_n(OP_SETM, 58);
    pulse_n(OP_ARM, 1);
    set_time(23, 57, 59);
    set_time(23, 58, 0);
    chk("snz_ring", o_ringing, 1);
    set_time(23, 58, 10);
    pulse_n(OP_SNZ, 1);
`ifdef ALARM_SNOOZE_EN
    chk("snz_after_ringing", o_ringing, 0);
    chk("snz_after_armed", o_armed, 1);
    set_time(0, 2, 59);
    chk("snz_before_target", o_ringing, 0);
    set_time(0, 3, 0);
    chk("snz_rering", o_ringing, 1);
`else
    chk("nosnz_ringing", o_ringing, 1);
    chk("nosnz_armed", o_armed, 1);
`endif

    // Minute glitch at 07:30:00 with alarm 07:31, then reset mid-ring
    do_reset();
    pulse_n(OP_SETH, 7);
    pulse_n(OP_SETM, 31);
    pulse_n(OP_ARM, 1);
    set_time(7, 29, 59);
    i_hour = 6'd7; i_min = 6'd31; i_sec = 6'd0;
    step(1);
    i_min = 6'd30;
    step(10);
    chk("glitch_no_ring", o_ringing, 0);
    set_time(7, 30, 59);
    set_time(7, 31, 0);
    chk("glitch_then_ring", o_ringing, 1);
    k = 0;
    while (!o_buzz && k < 50) begin step(1); k++; end
    chk("buzz_high_before_reset", o_buzz, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ringing", o_ringing, 0);
    chk("async_rst_buzz", o_buzz, 0);
    chk("async_rst_armed", o_armed, 0);

    // Random operations against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 4) begin
        pulse(r);
        m_op(r);
        step(2);
      end else begin
        if (r <= 7) nt = (m_t + 1) % 86400;
        else if (r <= 9) begin
          if (m_snz == 1) nt = (m_tgt * 60 + 86400 - 1) % 86400;
          else nt = ((m_ah * 60 + m_am) * 60 + 86400 - 2) % 86400;
        end else nt = $urandom_range(0, 86399);
        set_time(nt / 3600, (nt / 60) % 60, nt % 60);
        m_new_time(nt);
      end
      chk($sformatf("rnd%0d_armed", i), o_armed, m_on);
      chk($sformatf("rnd%0d_ringing", i), o_ringing, m_ring);
      chk($sformatf("rnd%0d_alm_hour", i), o_alm_hour, m_ah);
      chk($sformatf("rnd%0d_alm_min", i), o_alm_min, m_am);
      if (m_ring == 0) chk($sformatf("rnd%0d_buzz", i), o_buzz, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
